imm_ext_stage: RTL and testbench

- Registered, parametrised successor to the single-cycle immediate extender of the RISC-V core.
- Decodes the immediate from a 32-bit instruction for XLEN = 32 or 64.
- Adds CSR-zimm and shift-amount formats.
- Sits between fetch/decode and execute as one elastic pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous flush.

---
 rtl/imm_ext_pkg.sv | 24 ++
 rtl/imm_ext_comb.sv | 37 +++
 rtl/imm_ext_stage.sv | 121 ++++++++++++
 tb/tb_imm_ext_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared definitions for the immediate-extension stage.
//   op_type_e      - 3-bit instruction format selector (OP_I .. OP_SH)
//   XLEN_DEFAULT   - default datapath width
//   is_branch_fmt  - true for formats whose immediate is a pc-relative offset
package imm_ext_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_I  = 3'd0,
    OP_Z  = 3'd1,
    OP_S  = 3'd2,
    OP_B  = 3'd3,
    OP_U  = 3'd4,
    OP_J  = 3'd5,
    OP_R  = 3'd6,
    OP_SH = 3'd7
  } op_type_e;

  function automatic logic is_branch_fmt(op_type_e op);
    return (op == OP_B) || (op == OP_J);
  endfunction

endpackage

// File: rtl/imm_ext_comb.sv
// imm_ext_comb: purely combinational immediate extender.
//   inst     in   32    raw instruction word
//   op_type  in   3     format selector (imm_ext_pkg::op_type_e)
//   imm      out  XLEN  extended immediate
// Parameter XLEN selects 32- or 64-bit results.
module imm_ext_comb
  import imm_ext_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      op_type,
  output logic [XLEN-1:0] imm
);

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  // Size casts of $signed operands sign-extend to XLEN; unsigned operands
  // zero-extend.
  always_comb begin
    imm = '0;
    case (op_type_e'(op_type))
      OP_I:  imm = XLEN'($signed(inst[31:20]));
      OP_S:  imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      OP_B:  imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      OP_U:  imm = XLEN'($signed({inst[31:12], 12'b0}));
      OP_J:  imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      OP_Z:  imm = XLEN'(inst[19:15]);
      // RV64 shift amounts are 6 bits wide, RV32 only 5.
      OP_SH: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: one elastic pipeline stage that extends the immediate of a
// 32-bit instruction and carries a sideband tag, with a 2-entry
// (output register + skid register) buffer and synchronous flush.
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready = !skid_valid, registered)
//   in_inst, in_op_type, in_pc, in_tag   incoming instruction data
//   flush             drop held entries and any input accepted this cycle
//   out_valid/out_ready downstream handshake
//   out_imm, out_target, out_tag        registered entry
// Optional build macro IMM_EXT_BTARGET_EN: when defined, out_target holds
// pc + imm for B/J formats (0 otherwise); when undefined out_target is 0 and
// in_pc is ignored.
module imm_ext_stage
  import imm_ext_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_op_type,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] in_imm;
  entry_t          in_entry;
  entry_t          out_d, out_q, skid_d, skid_q;
  logic            out_valid_d, out_valid_q;
  logic            skid_valid_d, skid_valid_q;
  logic            accept, out_free;

  // Extension happens before storage so both buffer slots hold final values.
  imm_ext_comb #(.XLEN(XLEN)) u_ext (
    .inst    (in_inst),
    .op_type (in_op_type),
    .imm     (in_imm)
  );

  always_comb begin
    in_entry.imm = in_imm;
    in_entry.tag = in_tag;
`ifdef IMM_EXT_BTARGET_EN
    in_entry.target = is_branch_fmt(op_type_e'(in_op_type)) ? (in_pc + in_imm) : '0;
`else
    in_entry.target = '0;
`endif
  end

`ifndef IMM_EXT_BTARGET_EN
  logic unused_pc;
  assign unused_pc = ^in_pc;
`endif

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // Skid holds the older entry, so it always drains first; while it is
      // full in_ready is low and no new entry can arrive.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output is stalled: park the new entry in the skid slot.
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_imm    = out_q.imm;
  assign out_target = out_q.target;
  assign out_tag    = out_q.tag;

endmodule

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [2:0]  in_op_type = '0;
  logic [63:0] in_pc = '0;
  logic [7:0]  in_tag = '0;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32, out_target32;
  logic [63:0] out_imm64, out_target64;
  logic [7:0]  out_tag32, out_tag64;

  always #5 clk = ~clk;

  imm_ext_stage #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_op_type(in_op_type), .in_pc(in_pc[31:0]), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_target(out_target32), .out_tag(out_tag32)
  );

  imm_ext_stage #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_op_type(in_op_type), .in_pc(in_pc), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_target(out_target64), .out_tag(out_tag64)
  );

  typedef struct {
    longint unsigned imm32;
    longint unsigned tgt32;
    longint unsigned imm64;
    longint unsigned tgt64;
    logic [7:0]      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_done = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (arithmetic on instruction fields) ----
  function automatic longint unsigned fld(logic [31:0] inst, int hi, int lo);
    longint unsigned v = 64'(inst);
    return (v >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  function automatic longint unsigned sext(longint unsigned v, int bits);
    longint unsigned half = 64'd1 << (bits - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  function automatic longint unsigned xmask(int xlen);
    return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xlen) - 64'd1);
  endfunction

  function automatic longint unsigned ref_imm(int xlen, logic [31:0] inst, int op);
    longint unsigned r;
    case (op)
      0: r = sext(fld(inst, 31, 20), 12);
      1: r = fld(inst, 19, 15);
      2: r = sext(fld(inst, 31, 25) * 32 + fld(inst, 11, 7), 12);
      3: r = sext(fld(inst, 31, 31) * 4096 + fld(inst, 7, 7) * 2048
                  + fld(inst, 30, 25) * 32 + fld(inst, 11, 8) * 2, 13);
      4: r = sext(fld(inst, 31, 12) * 4096, 32);
      5: r = sext(fld(inst, 31, 31) * (64'd1 << 20) + fld(inst, 19, 12) * 4096
                  + fld(inst, 20, 20) * 2048 + fld(inst, 30, 21) * 2, 21);
      6: r = 0;
      default: r = (xlen == 64) ? fld(inst, 25, 20) : fld(inst, 24, 20);
    endcase
    return r & xmask(xlen);
  endfunction

  function automatic longint unsigned ref_tgt(int xlen, logic [31:0] inst, int op,
                                              longint unsigned pc);
`ifdef IMM_EXT_BTARGET_EN
    if (op == 3 || op == 5)
      return (pc + ref_imm(xlen, inst, op)) & xmask(xlen);
    return 0;
`else
    return 0;
`endif
  endfunction

  // ---------------- stimulus ---------------------------------------------
  // All tasks start and end at posedge+1.
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(logic [31:0] inst, logic [2:0] op, logic [63:0] pc, logic [7:0] tag,
                      bit ovr, logic [63:0] e32, logic [63:0] e64);
    exp_t e;
    bit   acc = 1'b0;
    e.imm32 = ref_imm(32, inst, int'(op));
    e.imm64 = ref_imm(64, inst, int'(op));
    e.tgt32 = ref_tgt(32, inst, int'(op), pc);
    e.tgt64 = ref_tgt(64, inst, int'(op), pc);
    e.tag   = tag;
    if (ovr) begin
      e.imm32 = e32;
      e.imm64 = e64;
    end
    in_valid = 1'b1; in_inst = inst; in_op_type = op; in_pc = pc; in_tag = tag;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk); #1;
      acc = in_ready32;
      if (acc) q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: tag %h never accepted", tag);
    end
  endtask

  task automatic do_flush(bit with_input, logic [7:0] tag);
    flush = 1'b1; in_valid = with_input; in_inst = 32'hFFF00093; in_op_type = 3'd0;
    in_tag = tag;
    @(negedge clk); #1;
    q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(string sfx);
    chk({"rst_out_valid32", sfx}, out_valid32, 0);
    chk({"rst_in_ready32", sfx}, in_ready32, 1);
    chk({"rst_imm32", sfx}, out_imm32, 0);
    chk({"rst_tgt32", sfx}, out_target32, 0);
    chk({"rst_tag32", sfx}, out_tag32, 0);
    chk({"rst_out_valid64", sfx}, out_valid64, 0);
    chk({"rst_in_ready64", sfx}, in_ready64, 1);
    chk({"rst_imm64", sfx}, out_imm64, 0);
    chk({"rst_tgt64", sfx}, out_target64, 0);
    chk({"rst_tag64", sfx}, out_tag64, 0);
  endtask

  // ---------------- monitor / scoreboard ---------------------------------
  always @(negedge clk) begin
    exp_t e;
    chk("out_valid32", out_valid32, q.size() > 0);
    chk("out_valid64", out_valid64, q.size() > 0);
    chk("in_ready32", in_ready32, q.size() < 2);
    chk("in_ready64", in_ready64, q.size() < 2);
    if (out_valid32 && out_ready && q.size() > 0) begin
      e = q.pop_front();
      chk("imm32", out_imm32, e.imm32);
      chk("tgt32", out_target32, e.tgt32);
      chk("tag32", out_tag32, e.tag);
      chk("imm64", out_imm64, e.imm64);
      chk("tgt64", out_target64, e.tgt64);
      chk("tag64", out_tag64, e.tag);
      $display("xfer tag=%h imm32=%h imm64=%h tgt64=%h", out_tag32, out_imm32, out_imm64,
               out_target64);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------------------------------
  initial begin
    #1;
    chk_reset_outputs("_init");
    idle(2);
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed formats, output always ready.
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 64'h0, 8'h10, 1, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    send(32'hFE112E23, 3'd2, 64'h0, 8'h11, 1, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    send(32'hFE000CE3, 3'd3, 64'h100, 8'h12, 1, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8);
    send(32'h800000B7, 3'd4, 64'h0, 8'h13, 1, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    send(32'h03F0D093, 3'd7, 64'h0, 8'h14, 1, 64'h1F, 64'h3F);
    send(32'h3400D073, 3'd1, 64'h0, 8'h15, 1, 64'h1, 64'h1);
    send(32'hDEADBEEF, 3'd6, 64'h0, 8'h16, 1, 64'h0, 64'h0);
    send(32'h0080006F, 3'd5, 64'h2000, 8'h17, 1, 64'h8, 64'h8);
    idle(3);

    // Backpressure: three back-to-back entries against a stalled output.
    out_ready = 1'b0;
    fork
      begin
        send(32'h00100093, 3'd0, 64'h0, 8'h01, 0, 0, 0);
        send(32'h00200093, 3'd0, 64'h0, 8'h02, 0, 0, 0);
        send(32'h00300093, 3'd0, 64'h0, 8'h03, 0, 0, 0);
      end
      begin
        idle(4);
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_drained", 64'(q.size()), 0);

    // Flush with both slots full and input presented.
    out_ready = 1'b0;
    send(32'h02100093, 3'd0, 64'h0, 8'h21, 0, 0, 0);
    send(32'h02200093, 3'd0, 64'h0, 8'h22, 0, 0, 0);
    do_flush(1, 8'h23);
    out_ready = 1'b1;
    idle(3);

    // Flush while an input is actually accepted.
    out_ready = 1'b0;
    send(32'h03100093, 3'd0, 64'h0, 8'h31, 0, 0, 0);
    do_flush(1, 8'h32);
    out_ready = 1'b1;
    idle(3);

    // Asynchronous reset between edges with both slots occupied.
    out_ready = 1'b0;
    send(32'h04100093, 3'd3, 64'h40, 8'h41, 0, 0, 0);
    send(32'h04200093, 3'd5, 64'h80, 8'h42, 0, 0, 0);
    @(negedge clk); #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("_async");
    q.delete();
    @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic with random downstream stalls.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom},
               8'($urandom_range(0, 255)), 0, 0, 0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    idle(5);
    chk("rand_drained", 64'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
